// File: rtl/regfile_pkg.sv
// Shared state encoding and helpers for the multiport register file.
// REGFILE_BYPASS_EN selects write-first reads; left undefined, reads are read-first.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rfState_e;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  // Address width for a register count; NREGS is a power of two, so this is exact.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Writeback/read bus between the decode-stage core logic (master) and the register file (slave).
interface regfile_multiport_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  import regfile_pkg::*;

  localparam int AW = clog2(NREGS);

  logic                ready;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;

  modport master (
    input  ready,
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    output ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );

endinterface

// File: rtl/regfile_rdport.sv
// One registered read port: optional write-first bypass, x0 masking, zero output while clearing.
// REGFILE_BYPASS_EN (through regfile_pkg::BYPASS_EN) enables the same-cycle bypass.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [AW-1:0]   rdAddr,
  input  logic [XLEN-1:0] arrayData,
  input  logic            wrFire,
  input  logic [AW-1:0]   wrAddr,
  input  logic [XLEN-1:0] wrData,
  output logic [XLEN-1:0] rdData
);

  logic [XLEN-1:0] nextData;
  logic            bypassHit;
  logic            zeroHit;

  // x0 masking and the clear phase both win over the bypass path.
  always_comb begin
    bypassHit = BYPASS_EN && wrFire && (wrAddr == rdAddr);
    zeroHit   = (ZERO_REG != 0) && (rdAddr == '0);
    nextData  = arrayData;
    if (bypassHit) begin
      nextData = wrData;
    end
    if (zeroHit || !run) begin
      nextData = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdData <= '0;
    end else begin
      rdData <= nextData;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised N-read/1-write register file with a post-reset clear sequencer.
// Define REGFILE_BYPASS_EN for write-first reads; otherwise reads return the pre-write value.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input logic                clk,
  input logic                rst_n,
  regfile_multiport_if.slave bus
);

  localparam int AW = clog2(NREGS);

  rfState_e            state;
  rfState_e            nextState;
  logic [AW-1:0]       clrPtr;
  logic [AW-1:0]       nextPtr;
  logic                run;
  logic                wrFire;
  logic                memWe;
  logic [AW-1:0]       memAddr;
  logic [XLEN-1:0]     memData;
  logic [XLEN-1:0]     mem [NREGS];
  logic [NRD*XLEN-1:0] rdDataBus;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_CLEAR;
      clrPtr <= '0;
    end else begin
      state  <= nextState;
      clrPtr <= nextPtr;
    end
  end

  // CLEAR walks every entry once, then RUN is held until the next reset.
  always_comb begin
    nextState = state;
    nextPtr   = clrPtr;
    case (state)
      ST_CLEAR: begin
        nextPtr = clrPtr + AW'(1);
        if (clrPtr == AW'(NREGS - 1)) begin
          nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        nextState = ST_RUN;
      end
    endcase
  end

  assign run       = (state == ST_RUN);
  assign bus.ready = run;
  assign wrFire    = run && bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  always_comb begin
    memWe   = wrFire;
    memAddr = bus.wr_addr;
    memData = bus.wr_data;
    if (!run) begin
      memWe   = 1'b1;
      memAddr = clrPtr;
      memData = '0;
    end
  end

  // Contents are deliberately not reset; the clear sequencer zeroes them instead.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memAddr] <= memData;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : gRdPort
    logic [AW-1:0]   portAddr;
    logic [XLEN-1:0] arrayData;

    assign portAddr  = bus.rd_addr[p*AW +: AW];
    assign arrayData = mem[portAddr];

    regfile_rdport #(
      .XLEN     (XLEN),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) uRdPort (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .rdAddr    (portAddr),
      .arrayData (arrayData),
      .wrFire    (wrFire),
      .wrAddr    (bus.wr_addr),
      .wrData    (bus.wr_data),
      .rdData    (rdDataBus[p*XLEN +: XLEN])
    );
  end

  assign bus.rd_data = rdDataBus;

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench: two register files (ZERO_REG=1 and ZERO_REG=0) driven in lockstep.
// Expected read data follows REGFILE_BYPASS_EN exactly as the design does.
module tb_regfile_multiport;
  import regfile_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = clog2(NREGS);

  logic                clk;
  logic                rst_n;
  logic                wrEn;
  logic [AW-1:0]       wrAddr;
  logic [XLEN-1:0]     wrData;
  logic [NRD*AW-1:0]   rdAddr;

  logic [XLEN-1:0]     memZ [NREGS];
  logic [XLEN-1:0]     memO [NREGS];
  logic                readyExp;
  int                  clearCnt;
  logic [XLEN-1:0]     expQ [$];
  int                  vectors = 0;
  int                  miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_multiport_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) busZ ();
  regfile_multiport_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) busO ();

  assign busZ.wr_en   = wrEn;
  assign busZ.wr_addr = wrAddr;
  assign busZ.wr_data = wrData;
  assign busZ.rd_addr = rdAddr;
  assign busO.wr_en   = wrEn;
  assign busO.wr_addr = wrAddr;
  assign busO.wr_data = wrData;
  assign busO.rd_addr = rdAddr;

  regfile_multiport #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dutZ (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busZ)
  );

  regfile_multiport #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(0)) dutO (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busO)
  );

  function automatic logic [XLEN-1:0] dutData(input int k);
    case (k)
      0:       return busZ.rd_data[0 +: XLEN];
      1:       return busZ.rd_data[XLEN +: XLEN];
      2:       return busO.rd_data[0 +: XLEN];
      default: return busO.rd_data[XLEN +: XLEN];
    endcase
  endfunction

  // Reference read: zero while clearing, x0 masked when hardwired, optional write-first.
  function automatic logic [XLEN-1:0] expRead(input logic zero, input logic [AW-1:0] a,
                                              input logic we, input logic [AW-1:0] wa,
                                              input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] r;
    if (!readyExp) return '0;
    if (zero && a == '0) return '0;
    r = zero ? memZ[a] : memO[a];
    if (BYPASS_EN && we && wa == a) r = wd;
    return r;
  endfunction

  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    wrEn   = we;
    wrAddr = wa;
    wrData = wd;
    rdAddr = {ra1, ra0};
    expQ.push_back(expRead(1'b1, ra0, we, wa, wd));
    expQ.push_back(expRead(1'b1, ra1, we, wa, wd));
    expQ.push_back(expRead(1'b0, ra0, we, wa, wd));
    expQ.push_back(expRead(1'b0, ra1, we, wa, wd));
    @(posedge clk);
    if (!readyExp) begin
      memZ[clearCnt] = '0;
      memO[clearCnt] = '0;
      clearCnt++;
      if (clearCnt == NREGS) readyExp = 1'b1;
    end else if (we) begin
      if (wa != '0) memZ[wa] = wd;
      memO[wa] = wd;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    wrEn     = 1'b0;
    wrAddr   = '0;
    wrData   = '0;
    rdAddr   = '0;
    readyExp = 1'b0;
    clearCnt = 0;
    #2;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (dutData(k) !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_rd%0d: got %h, expected 0", k, dutData(k));
      end
    end
    vectors++;
    if ({busZ.ready, busO.ready} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got %b, expected 00", {busZ.ready, busO.ready});
    end
  endtask

  // Clear sequence with a write attempt on the third edge that must be dropped.
  task automatic test_clear(input string tag);
    logic [XLEN-1:0] want;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= NREGS; i++) begin
      step(i == 3, AW'(3), 32'hA5, AW'(i), AW'(NREGS - i));
      for (int k = 0; k < 4; k++) begin
        want = expQ.pop_front();
        vectors++;
        if (dutData(k) !== want) begin
          miscompares++;
          $display("[TB] FAIL %s_rd%0d cycle %0d: got %h, expected %h", tag, k, i, dutData(k), want);
        end
      end
      vectors++;
      if ({busZ.ready, busO.ready} !== {2{readyExp}}) begin
        miscompares++;
        $display("[TB] FAIL %s_ready cycle %0d: got %b, expected %b", tag, i,
                 {busZ.ready, busO.ready}, {2{readyExp}});
      end
    end
  endtask

  task automatic test_read_all(input string tag);
    logic [XLEN-1:0] want;
    for (int i = 0; i < NREGS / 2; i++) begin
      step(1'b0, '0, '0, AW'(i), AW'(i + NREGS / 2));
      for (int k = 0; k < 4; k++) begin
        want = expQ.pop_front();
        vectors++;
        if (dutData(k) !== want || want !== '0) begin
          miscompares++;
          $display("[TB] FAIL %s_rd%0d addr %0d: got %h, expected 0", tag, k, i, dutData(k));
        end
      end
    end
  endtask

  // Write, then one or more reads; covers x5 dual-port, x0 masking and same-cycle x7.
  task automatic test_write_read(input string tag, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] want;
    step(1'b1, a, d, a, a);
    for (int k = 0; k < 4; k++) begin
      want = expQ.pop_front();
      vectors++;
      if (dutData(k) !== want) begin
        miscompares++;
        $display("[TB] FAIL %s_same_rd%0d: got %h, expected %h", tag, k, dutData(k), want);
      end
    end
    step(1'b0, '0, '0, a, a);
    for (int k = 0; k < 4; k++) begin
      want = expQ.pop_front();
      vectors++;
      if (dutData(k) !== want) begin
        miscompares++;
        $display("[TB] FAIL %s_next_rd%0d: got %h, expected %h", tag, k, dutData(k), want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] want;
    logic [AW-1:0]   wa;
    logic [AW-1:0]   ra0;
    for (int i = 0; i < 40; i++) begin
      wa  = AW'($urandom_range(0, NREGS - 1));
      ra0 = ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, NREGS - 1));
      step(1'($urandom_range(0, 1)), wa, $urandom, ra0, AW'($urandom_range(0, NREGS - 1)));
      for (int k = 0; k < 4; k++) begin
        want = expQ.pop_front();
        vectors++;
        if (dutData(k) !== want) begin
          miscompares++;
          $display("[TB] FAIL b2b_rd%0d step %0d: got %h, expected %h", k, i, dutData(k), want);
        end
      end
    end
  endtask

  task automatic test_midrun_reset();
    logic [XLEN-1:0] want;
    for (int i = 0; i < NREGS; i++) begin
      step(1'b1, AW'(i), $urandom | 32'h1, AW'(i), AW'(i + 1));
      for (int k = 0; k < 4; k++) begin
        want = expQ.pop_front();
        vectors++;
        if (dutData(k) !== want) begin
          miscompares++;
          $display("[TB] FAIL fill_rd%0d addr %0d: got %h, expected %h", k, i, dutData(k), want);
        end
      end
    end
    wrEn     = 1'b1;
    wrAddr   = AW'(9);
    wrData   = 32'hCAFEF00D;
    rdAddr   = {AW'(9), AW'(9)};
    rst_n    = 1'b0;
    readyExp = 1'b0;
    clearCnt = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (dutData(k) !== '0) begin
        miscompares++;
        $display("[TB] FAIL midrst_rd%0d: got %h, expected 0", k, dutData(k));
      end
    end
    vectors++;
    if ({busZ.ready, busO.ready} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL midrst_ready: got %b, expected 00", {busZ.ready, busO.ready});
    end
    test_clear("reclear");
    test_read_all("reread");
  endtask

  initial begin
    $display("[TB] regfile_multiport bench, bypass=%0d", BYPASS_EN);
    test_reset();
    test_clear("clear");
    test_read_all("readall");
    test_write_read("x5", AW'(5), 32'hDEADBEEF);
    test_write_read("x0", AW'(0), 32'hFFFFFFFF);
    test_write_read("x7", AW'(7), 32'h00001234);
    test_back_to_back();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
